// File: rtl/mult_fixo_rr_sched.sv
// -----------------------------------------------------------------------------
// mult_fixo_rr_sched
// Round-robin scheduler sharing one unsigned fixed-point multiplier
// (Q(W-FRAC).FRAC) among N_REQ requesters. One transaction is in flight at a
// time: the winning requester's operands are latched, multiplied, and the
// tagged, truncated result is held until the consumer accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request, held with operands until req_ready
//   req_a      operand A, requester i at [i*W +: W]
//   req_b      operand B, requester i at [i*W +: W]
//   req_ready  one-hot accept strobe (combinational, IDLE only)
//   rsp_valid  result available
//   rsp_ready  consumer accepts the result
//   rsp_id     index of the requester owning the result
//   rsp_prod   full_product[FRAC+W-1:FRAC], truncated
//   rsp_ovf    OR of the product bits above the result field
//   busy       a transaction is in flight
// -----------------------------------------------------------------------------
module mult_fixo_rr_sched #(
   parameter int N_REQ = 4,
   parameter int W     = 8,
   parameter int FRAC  = 3,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [IDW-1:0]     rsp_id,
   output logic [W-1:0]       rsp_prod,
   output logic               rsp_ovf,
   output logic               busy
);

   localparam int PW = 2 * W;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state, state_nxt;
   logic [IDW-1:0]    rr_ptr, ptr_nxt;
   logic [IDW-1:0]    grant_idx;
   logic              grant_vld;
   logic [IDW:0]      srch;
   logic [W-1:0]      a_arr [N_REQ];
   logic [W-1:0]      b_arr [N_REQ];

   logic [W-1:0]      a_p0, b_p0;
   logic [IDW-1:0]    id_p0;
   logic [PW-1:0]     prod_p1;
   logic [IDW-1:0]    id_p1;

   function automatic logic [W-1:0] trunc_prod(input logic [PW-1:0] p);
      return p[FRAC+W-1:FRAC];
   endfunction

   function automatic logic ovf_flag(input logic [PW-1:0] p);
      return |p[PW-1:FRAC+W];
   endfunction

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         a_arr[i] = req_a[i*W +: W];
         b_arr[i] = req_b[i*W +: W];
      end
   end

   // Search starts at rr_ptr and wraps modulo N_REQ; the first valid wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      srch      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         srch = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (srch >= (IDW+1)'(N_REQ))
            srch = srch - (IDW+1)'(N_REQ);
         if (!grant_vld && req_valid[srch[IDW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = srch[IDW-1:0];
         end
      end
   end

   assign ptr_nxt = (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + IDW'(1);

   // The accept strobe is forced low while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && grant_vld)
         req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = CALC;
         CALC:    state_nxt = DONE;
         DONE:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && grant_vld)
            rr_ptr <= ptr_nxt;
      end
   end

   // Stage p0: operand capture on the accept edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_p0  <= '0;
         b_p0  <= '0;
         id_p0 <= '0;
      end else if (state == IDLE && grant_vld) begin
         a_p0  <= a_arr[grant_idx];
         b_p0  <= b_arr[grant_idx];
         id_p0 <= grant_idx;
      end
   end

   // Stage p1: full-width product, held through DONE and beyond
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_p1 <= '0;
         id_p1   <= '0;
      end else if (state == CALC) begin
         prod_p1 <= PW'(a_p0) * PW'(b_p0);
         id_p1   <= id_p0;
      end
   end

   assign rsp_prod  = trunc_prod(prod_p1);
   assign rsp_ovf   = ovf_flag(prod_p1);
   assign rsp_id    = id_p1;
   assign rsp_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mult_fixo_rr_sched.sv
module tb_mult_fixo_rr_sched;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int FRAC = 3;
   localparam int IDW  = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_a, req_b;
   logic [N-1:0]   req_ready;
   logic           rsp_valid, rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic [W-1:0]   rsp_prod;
   logic           rsp_ovf, busy;

   int n_chk  = 0;
   int n_fail = 0;

   mult_fixo_rr_sched #(.N_REQ(N), .W(W), .FRAC(FRAC), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_ovf(rsp_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Transaction-level view: phase 0 waiting, 1 multiplying, 2 result offered.
   int          m_ptr, m_phase, m_gid, m_rid;
   int unsigned m_a, m_b, m_full;

   function automatic int pick(input int ptr, input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ptr = 0; m_phase = 0; m_gid = 0; m_rid = 0;
         m_a = 0; m_b = 0; m_full = 0;
      end else begin
         case (m_phase)
            0: begin
               int g;
               g = pick(m_ptr, req_valid);
               if (g >= 0) begin
                  m_a     = (req_a >> (g*W)) & 8'hFF;
                  m_b     = (req_b >> (g*W)) & 8'hFF;
                  m_gid   = g;
                  m_ptr   = (g + 1) % N;
                  m_phase = 1;
               end
            end
            1: begin
               m_full  = m_a * m_b;
               m_rid   = m_gid;
               m_phase = 2;
            end
            default: if (rsp_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      int g;
      logic [N-1:0] exp_rdy;
      g = pick(m_ptr, req_valid);
      exp_rdy = '0;
      if (rst_n && m_phase == 0 && g >= 0) exp_rdy = N'(1) << g;
      check("mdl_req_ready", req_ready, exp_rdy);
      check("mdl_busy", busy, (m_phase != 0));
      check("mdl_rsp_valid", rsp_valid, (m_phase == 2));
      check("mdl_rsp_id", rsp_id, m_rid);
      check("mdl_rsp_prod", rsp_prod, (m_full >> FRAC) & 32'hFF);
      check("mdl_rsp_ovf", rsp_ovf, ((m_full >> (FRAC + W)) != 0));
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      bit got;
      got = 0;
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_valid[i] = 1'b1;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (req_ready[i]) begin got = 1; break; end
      end
      if (got) begin
         @(posedge clk); #1;
      end else begin
         check("accept_timeout", 0, 1);
      end
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit got;
      got = 0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (rsp_valid) begin got = 1; break; end
      end
      if (!got) check({tag, "_rsp_timeout"}, 0, 1);
   endtask

   logic [IDW-1:0] exp_ids [5];
   logic [W-1:0]   exp_prods [5];

   initial begin
      exp_ids   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_prods = '{8'h08, 8'h10, 8'h18, 8'h20, 8'h08};

      // Reset with all requests high: no accept strobe may leak out.
      rst_n = 1'b0; rsp_ready = 1'b1;
      req_valid = '1; req_a = '0; req_b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", req_ready, 4'h0);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_prod", rsp_prod, 8'h00);
      check("rst_rsp_id", rsp_id, 2'd0);
      req_valid = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2.0 * 3.0 with latency check
      do_req(0, 8'h10, 8'h18);
      check("t1_cyc1_valid", rsp_valid, 0);
      @(posedge clk); #1;
      check("t1_cyc2_valid", rsp_valid, 1);
      check("t1_prod", rsp_prod, 8'h30);
      check("t1_ovf", rsp_ovf, 0);
      check("t1_id", rsp_id, 2'd0);
      @(posedge clk); #1;

      // Overflow
      do_req(2, 8'hFF, 8'hFF);
      wait_done("t2");
      check("t2_prod", rsp_prod, 8'hC0);
      check("t2_ovf", rsp_ovf, 1);
      check("t2_id", rsp_id, 2'd2);
      @(posedge clk); #1;

      // Truncation
      do_req(1, 8'h01, 8'h01);
      wait_done("t3a");
      check("t3a_prod", rsp_prod, 8'h00);
      check("t3a_ovf", rsp_ovf, 0);
      @(posedge clk); #1;
      do_req(3, 8'h08, 8'h0C);
      wait_done("t3b");
      check("t3b_prod", rsp_prod, 8'h0C);
      check("t3b_id", rsp_id, 2'd3);
      @(posedge clk); #1;

      // Round-robin over all requesters held high
      rst_n = 1'b0; #2; rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = 8'(8 * (i + 1));
         req_b[i*W +: W] = 8'h08;
      end
      req_valid = '1;
      for (int op = 0; op < 5; op++) begin
         wait_done("t4");
         check("t4_id", rsp_id, exp_ids[op]);
         check("t4_prod", rsp_prod, exp_prods[op]);
         if (op == 4) req_valid = '0;
         @(posedge clk); #1;
      end

      // Backpressure, with a waiting request on requester 3
      rsp_ready = 1'b0;
      req_a[3*W +: W] = 8'h08; req_b[3*W +: W] = 8'h08;
      do_req(1, 8'h20, 8'h20);
      req_valid[3] = 1'b1;
      wait_done("t5");
      for (int c = 0; c < 5; c++) begin
         check("t5_valid", rsp_valid, 1);
         check("t5_prod", rsp_prod, 8'h80);
         check("t5_id", rsp_id, 2'd1);
         check("t5_ready", req_ready, 4'h0);
         check("t5_busy", busy, 1);
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("t5_rel_busy", busy, 0);
      check("t5_rel_valid", rsp_valid, 0);
      check("t5_rel_ready", req_ready, 4'b1000);
      do_req(3, 8'h08, 8'h08);
      wait_done("t5b");
      check("t5b_prod", rsp_prod, 8'h08);
      check("t5b_id", rsp_id, 2'd3);
      @(posedge clk); #1;

      // Reset during CALC
      do_req(0, 8'h10, 8'h10);
      rst_n = 1'b0;
      #1;
      check("t6_busy", busy, 0);
      check("t6_valid", rsp_valid, 0);
      check("t6_prod", rsp_prod, 8'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_after_valid", rsp_valid, 0);
      req_valid = 4'b1001;
      @(negedge clk);
      check("t6_ptr_zero", req_ready, 4'b0001);
      @(posedge clk); #1;
      req_valid = '0;
      wait_done("t6");
      check("t6_prod_new", rsp_prod, 8'h20);
      check("t6_id_new", rsp_id, 2'd0);
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
